// File: rtl/slow_chain_reader.sv
// Snap/shift sequencer that drains the slow snapshot chain onto a byte stream.
// Optional trailing XOR checksum byte when SLOW_READER_CKSUM_EN is defined.
module slow_chain_reader #(
   parameter int n_bytes   = 8,
   parameter int snap_wait = 17,
   parameter int pace      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic [7:0] chain_in,
   output logic       slow_op,
   output logic       slow_snap,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       dout_last,
   output logic       busy,
   output logic [7:0] overrun
);

   typedef enum logic [2:0] {
      IDLE, SNAP, SETTLE, CAPT, HOLD, SHIFT, GAP, CKSUM
   } state_t;

   localparam logic [15:0] SETTLE_LD = 16'(snap_wait - 1);
   localparam logic [15:0] GAP_LD    = 16'(pace - 1);
   localparam logic [7:0]  N_LAST    = 8'(n_bytes);
   localparam logic [7:0]  N_PREV    = 8'(n_bytes - 1);
`ifdef SLOW_READER_CKSUM_EN
   localparam logic        CKS       = 1'b1;
`else
   localparam logic        CKS       = 1'b0;
`endif

   state_t      state, state_nx;
   logic [15:0] cnt;
   logic [7:0]  idx;
   logic        accept;

   assign accept = dout_valid & dout_ready;
   assign busy   = (state != IDLE);

   always_comb begin
      state_nx  = state;
      slow_op   = 1'b0;
      slow_snap = 1'b0;
      unique case (state)
         IDLE:   if (trig) state_nx = SNAP;
         SNAP: begin
            slow_op   = 1'b1;
            slow_snap = 1'b1;
            state_nx  = SETTLE;
         end
         // settle covers snap_wait-1 cycles so capture lands snap_wait after the pulse
         SETTLE: if (cnt <= 16'd1) state_nx = CAPT;
         CAPT:   state_nx = HOLD;
         HOLD: begin
            if (accept) begin
               if (idx == N_LAST) state_nx = CKS ? CKSUM : IDLE;
               else               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            slow_op  = 1'b1;
            state_nx = GAP;
         end
         GAP:    if (cnt == 16'd0) state_nx = CAPT;
         CKSUM:  if (accept) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef SLOW_READER_CKSUM_EN
   logic [7:0] xr;

   always_ff @(posedge clk) begin
      if (rst) begin
         xr <= 8'h00;
      end else if (state == SNAP) begin
         xr <= 8'h00;
      end else if (state == CAPT) begin
         xr <= xr ^ chain_in;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 16'd0;
         idx        <= 8'd0;
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         overrun    <= 8'h00;
      end else begin
         state <= state_nx;
         if (trig && state != IDLE && overrun != 8'hFF)
            overrun <= overrun + 8'd1;
         case (state)
            SNAP: begin
               cnt <= SETTLE_LD;
               idx <= 8'd0;
            end
            SETTLE: if (cnt != 16'd0) cnt <= cnt - 16'd1;
            CAPT: begin
               dout       <= chain_in;
               dout_valid <= 1'b1;
               idx        <= idx + 8'd1;
               dout_last  <= (idx == N_PREV) & ~CKS;
            end
            HOLD: begin
               if (accept) begin
                  dout_valid <= 1'b0;
                  dout_last  <= 1'b0;
               end
            end
            SHIFT: cnt <= GAP_LD;
            GAP:   if (cnt != 16'd0) cnt <= cnt - 16'd1;
`ifdef SLOW_READER_CKSUM_EN
            CKSUM: begin
               if (!dout_valid) begin
                  dout       <= xr;
                  dout_valid <= 1'b1;
                  dout_last  <= 1'b1;
               end else if (dout_ready) begin
                  dout_valid <= 1'b0;
                  dout_last  <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_slow_chain_reader.sv
// Directed/randomized bench for slow_chain_reader with a shift-chain model.
// Two instances: default geometry and n_bytes=1/pace=1.
module tb_slow_chain_reader;

   localparam int NB = 8;
   localparam int SW = 17;
   localparam int PC = 2;
`ifdef SLOW_READER_CKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int FRAME_BUSY = 1 + (SW - 1) + 2 * NB + (NB - 1) * (1 + PC) + 2 * CK;

   logic       clk = 1'b0;
   logic       rst, trig, dout_ready;
   logic [7:0] chain_in, dout, overrun;
   logic       slow_op, slow_snap, dout_valid, dout_last, busy;

   logic       trig_b, ready_b;
   logic [7:0] dout_b, overrun_b;
   logic       op_b, snap_b, valid_b, last_b, busy_b;

   always #5 clk = ~clk;

   slow_chain_reader #(.n_bytes(NB), .snap_wait(SW), .pace(PC)) dut (
      .clk(clk), .rst(rst), .trig(trig), .chain_in(chain_in),
      .slow_op(slow_op), .slow_snap(slow_snap), .dout(dout),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .busy(busy), .overrun(overrun)
   );

   logic [7:0] snapb, chainb;

   slow_chain_reader #(.n_bytes(1), .snap_wait(SW), .pace(1)) dut_b (
      .clk(clk), .rst(rst), .trig(trig_b), .chain_in(chainb),
      .slow_op(op_b), .slow_snap(snap_b), .dout(dout_b),
      .dout_valid(valid_b), .dout_ready(ready_b),
      .dout_last(last_b), .busy(busy_b), .overrun(overrun_b)
   );

   // chain model: snapshot loads the bytes the bench chose, shift advances one byte
   logic [7:0] snapv [NB];
   logic [7:0] chain [NB];
   int snaps = 0, shifts = 0, dbl = 0, snaps_b = 0, shifts_b = 0;
   logic prev_op = 1'b0;

   assign chain_in = chain[0];

   always @(posedge clk) begin
      if (slow_op && slow_snap) begin
         chain <= snapv;
         snaps <= snaps + 1;
      end else if (slow_op) begin
         for (int i = 0; i < NB - 1; i++) chain[i] <= chain[i + 1];
         chain[NB - 1] <= 8'h00;
         shifts <= shifts + 1;
      end
      if (slow_op && prev_op) dbl <= dbl + 1;
      prev_op <= slow_op;
      if (op_b && snap_b) begin
         chainb  <= snapb;
         snaps_b <= snaps_b + 1;
      end else if (op_b) begin
         shifts_b <= shifts_b + 1;
      end
   end

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_over(input int samples);
      int o = 0, pos = 0;
      for (int s = 0; s < samples; s++) begin
         if (pos != 0) o++;
         pos = (pos + 1) % (FRAME_BUSY + 1);
      end
      return (o > 255) ? 255 : o;
   endfunction

   task automatic run_frame(input int rmode, input string tag);
      logic [7:0] exp_q[$];
      logic [7:0] x = 8'h00, held = 8'h00;
      int s0 = shifts, n0 = snaps, d0 = dbl;
      int k = 0, t, first = -1, prevt = 0;
      logic stalled = 1'b0;
      for (int i = 0; i < NB; i++) begin
         exp_q.push_back(snapv[i]);
         x ^= snapv[i];
      end
      if (CK != 0) exp_q.push_back(x);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      t = 1;
      chk({tag, "_snap"}, {30'd0, slow_op, slow_snap}, 32'd3);
      while (k < exp_q.size() && t < 3000) begin
         if (dout_valid) begin
            if (!stalled) begin
               if (first < 0) begin
                  first = t;
                  chk({tag, "_lat"}, t, 2 + SW);
               end else if (rmode == 0 && k < NB) begin
                  chk({tag, "_b2b"}, t - prevt, PC + 3);
               end
               prevt = t;
            end else begin
               chk({tag, "_hold"}, dout, held);
            end
            dout_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (dout_ready) begin
               chk({tag, "_data"}, dout, exp_q[k]);
               chk({tag, "_last"}, dout_last, (k == exp_q.size() - 1));
               chk({tag, "_shcnt"}, shifts - s0, (k < NB - 1) ? k : NB - 1);
               k++;
               stalled = 1'b0;
            end else begin
               held = dout;
               stalled = 1'b1;
            end
         end else begin
            dout_ready = 1'($urandom_range(0, 1));
         end
         tick();
         t++;
      end
      chk({tag, "_done"}, k, exp_q.size());
      dout_ready = 1'b0;
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_snaps"}, snaps - n0, 1);
      chk({tag, "_shifts"}, shifts - s0, NB - 1);
      chk({tag, "_dbl"}, dbl - d0, 0);
   endtask

   initial begin
      int t, cnt, ops;
      rst = 1'b1;
      trig = 1'b0;
      dout_ready = 1'b0;
      trig_b = 1'b0;
      ready_b = 1'b0;
      snapb = 8'h00;
      for (int i = 0; i < NB; i++) snapv[i] = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", dout_valid, 1'b0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_last", dout_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_over", overrun, 8'h00);
      chk("rst_op", {slow_op, slow_snap}, 2'b00);
      tick();

      // 1: fixed bytes, ready held high
      for (int i = 0; i < NB; i++) snapv[i] = 8'((i + 1) * 8'h11);
      run_frame(0, "t1");

      // 2: random bytes, random sparse ready
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NB; i++) snapv[i] = 8'($urandom);
         run_frame(1, "t2");
      end

      // 3: trig held high, overrun saturates
      dout_ready = 1'b1;
      trig = 1'b1;
      repeat (55) tick();
      chk("t3_over55", overrun, exp_over(55));
      repeat (55) tick();
      chk("t3_over110", overrun, exp_over(110));
      repeat (250) tick();
      chk("t3_sat", overrun, 8'hFF);
      trig = 1'b0;
      t = 0;
      while (busy && t < 200) begin
         tick();
         t++;
      end
      chk("t3_idle", busy, 1'b0);
      dout_ready = 1'b0;
      tick();

      // 4: reset during 4th byte hold
      for (int i = 0; i < NB; i++) snapv[i] = 8'($urandom);
      dout_ready = 1'b1;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      cnt = 0;
      t = 0;
      while (t < 200) begin
         if (dout_valid) begin
            cnt++;
            if (cnt == 4) break;
         end
         tick();
         t++;
      end
      chk("t4_reach", cnt, 4);
      dout_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_valid", dout_valid, 1'b0);
      chk("t4_dout", dout, 8'h00);
      chk("t4_last", dout_last, 1'b0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_over", overrun, 8'h00);
      chk("t4_op", slow_op, 1'b0);
      ops = snaps + shifts;
      repeat (30) tick();
      chk("t4_quiet", snaps + shifts, ops);
      for (int i = 0; i < NB; i++) snapv[i] = 8'($urandom);
      run_frame(0, "t4b");

      // 5: single-byte instance
      snapb = 8'($urandom);
      cnt = snaps_b;
      ops = shifts_b;
      trig_b = 1'b1;
      tick();
      trig_b = 1'b0;
      t = 1;
      while (!valid_b && t < 100) begin
         tick();
         t++;
      end
      chk("t5_lat", t, 2 + SW);
      chk("t5_data", dout_b, snapb);
      chk("t5_last", last_b, (CK == 0));
      ready_b = 1'b1;
      tick();
      if (CK != 0) begin
         tick();
         chk("t5_ck_valid", valid_b, 1'b1);
         chk("t5_ck_data", dout_b, snapb);
         chk("t5_ck_last", last_b, 1'b1);
         tick();
      end
      ready_b = 1'b0;
      chk("t5_busy", busy_b, 1'b0);
      chk("t5_snaps", snaps_b - cnt, 1);
      chk("t5_shifts", shifts_b - ops, 0);

      // 6: one-hot bytes, checksum 0xFF when enabled
      for (int i = 0; i < NB; i++) snapv[i] = 8'(1 << i);
      run_frame(0, "t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
